// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded tenure and a dead cycle between owners.
// Grant is registered: a request sampled in IDLE is granted on the next edge.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // MAX_HOLD == 2**CNT_W lands on the all-ones count, so the counter never wraps.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       last_idx, last_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             exp_q, exp_nxt;

  logic [1:0]       cand;
  logic [1:0]       pick;
  logic             pick_vld;

  // Rotating scan starting just after the previous owner.
  always_comb begin
    cand     = 2'd0;
    pick     = 2'd0;
    pick_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_idx + 2'(k);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 2'd0;
      last_idx <= 2'd3;
      hold_cnt <= '0;
      exp_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last_idx <= last_nxt;
      hold_cnt <= hold_nxt;
      exp_q    <= exp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_idx;
    hold_nxt  = hold_cnt;
    exp_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (en && pick_vld) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        // A voluntary drop takes precedence, so expired only flags a real cut.
        if (!req[owner]) begin
          state_nxt = RELEASE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RELEASE;
          exp_nxt   = 1'b1;
        end else begin
          hold_nxt  = hold_cnt + 1'b1;
        end
      end
      RELEASE: begin
        last_nxt  = owner;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_valid = (state == GRANT);
    gnt       = gnt_valid ? (4'b0001 << owner) : 4'b0000;
    gnt_idx   = owner;
    expired   = exp_q;
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboarded bench for rr_arbiter_4: a tenure/cooldown model predicts each cycle's outputs.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .expired  (expired)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       exp;
    logic       rst;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the resource, for how long, and how many dead cycles remain.
  int m_owner  = -1;
  int m_tenure = 0;
  int m_cool   = 0;
  int m_last   = 3;
  bit m_exp    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input logic [3:0] q);
    if (!r) begin
      m_owner = -1;
      m_tenure = 0;
      m_cool  = 0;
      m_last  = 3;
      m_exp   = 0;
    end else begin
      m_exp = 0;
      if (m_owner >= 0) begin
        if (!q[m_owner] || m_tenure == MAX_HOLD) begin
          m_exp   = q[m_owner];
          m_last  = m_owner;
          m_owner = -1;
          m_cool  = 1;
        end else begin
          m_tenure++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (e && q != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (m_owner < 0 && q[c]) begin
            m_owner  = c;
            m_tenure = 1;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input logic [3:0] q);
    exp_t x;
    @(negedge clk);
    rst_n = r;
    en    = e;
    req   = q;
    model_step(r, e, q);
    x.vld = (m_owner >= 0);
    x.idx = x.vld ? 2'(m_owner) : 2'd0;
    x.gnt = x.vld ? (4'b0001 << x.idx) : 4'b0000;
    x.exp = m_exp;
    x.rst = !r;
    exp_q.push_back(x);
  endtask

  task automatic drive_n(input int n, input bit r, input bit e, input logic [3:0] q);
    for (int i = 0; i < n; i++) drive(r, e, q);
  endtask

  // Monitor: trackers for tenure length, zero-gap and starvation bound.
  int         run_len  = 0;
  int         zero_run = 0;
  bit         had_gnt  = 0;
  logic [3:0] prev_gnt = 4'b0000;
  int         waits[4] = '{0, 0, 0, 0};

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("gnt", 32'(gnt), 32'(x.gnt));
        chk("gnt_valid", 32'(gnt_valid), 32'(x.vld));
        chk("expired", 32'(expired), 32'(x.exp));
        if (x.vld || x.rst) chk("gnt_idx", 32'(gnt_idx), 32'(x.idx));
        chk("gnt_decode", 32'(gnt), gnt_valid ? 32'(4'b0001 << gnt_idx) : 32'd0);
        chk("exp_vs_valid", 32'(expired && gnt_valid), 32'd0);
        if (x.rst) begin
          run_len = 0;
          zero_run = 0;
          had_gnt = 0;
          for (int i = 0; i < 4; i++) waits[i] = 0;
        end else begin
          for (int i = 0; i < 4; i++) if (!req[i]) waits[i] = 0;
          if (gnt != 4'b0000) begin
            if (prev_gnt == 4'b0000) begin
              if (had_gnt) chk("gap_ge_2", 32'(zero_run >= 2), 32'd1);
              for (int i = 0; i < 4; i++) begin
                if (gnt[i]) waits[i] = 0;
                else if (req[i]) begin
                  waits[i]++;
                  chk("starve_le_3", 32'(waits[i] <= 3), 32'd1);
                end
              end
              run_len = 0;
            end else begin
              chk("no_direct_switch", 32'(gnt), 32'(prev_gnt));
            end
            run_len++;
            had_gnt = 1;
            zero_run = 0;
          end else begin
            if (prev_gnt != 4'b0000) chk("tenure_le_max", 32'(run_len <= MAX_HOLD), 32'd1);
            zero_run++;
          end
        end
        prev_gnt = x.rst ? 4'b0000 : gnt;
      end
    end
  end

  initial begin
    logic [3:0] rq;
    bit         re;
    bit         rr;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;

    drive_n(3, 0, 0, 4'b0000);
    // All four contending: full rotation with forced cuts.
    drive_n(46, 1, 1, 4'b1111);
    drive_n(4, 1, 1, 4'b0000);
    // Voluntary release after a short tenure.
    drive_n(5, 1, 1, 4'b0100);
    drive_n(4, 1, 1, 4'b0000);
    drive_n(3, 1, 1, 4'b1001);
    drive_n(4, 1, 1, 4'b0000);
    // Lone requester re-granted after each cut.
    drive_n(22, 1, 1, 4'b0010);
    drive_n(4, 1, 1, 4'b0000);
    // Enable gating only blocks new grants.
    drive_n(5, 1, 0, 4'b1000);
    drive_n(3, 1, 1, 4'b1000);
    drive_n(4, 1, 0, 4'b1000);
    drive_n(4, 1, 0, 4'b0000);
    drive_n(3, 1, 1, 4'b0000);
    // Reset mid-tenure restores priority to requester 0.
    drive_n(4, 1, 1, 4'b0011);
    drive_n(1, 0, 1, 4'b0011);
    drive_n(14, 1, 1, 4'b0011);
    drive_n(4, 1, 1, 4'b0000);

    rq = 4'b0000;
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      re = ($urandom_range(0, 9) != 0);
      rr = ($urandom_range(0, 499) != 0);
      drive(rr, re, rq);
    end
    drive_n(4, 1, 1, 4'b0000);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
